// File: rtl/muldiv_pkg.sv
// Shared types and constants for the EX-stage HI/LO unit.
//   md_op_t    : operation codes presented on ex_muldiv.op
//   md_state_t : control FSM states
//   md_acc_t   : how the multiplier result is merged into {hi,lo}
//   DIV_CYCLES : iterations of the radix-2 divider
package muldiv_pkg;

    typedef enum logic [3:0] {
        OpNone  = 4'd0,
        OpMult  = 4'd1,
        OpMultu = 4'd2,
        OpDiv   = 4'd3,
        OpDivu  = 4'd4,
        OpMthi  = 4'd5,
        OpMtlo  = 4'd6,
        OpMadd  = 4'd7,
        OpMaddu = 4'd8,
        OpMsub  = 4'd9,
        OpMsubu = 4'd10
    } md_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } md_state_t;

    typedef enum logic [1:0] {
        AccNone = 2'd0,
        AccAdd  = 2'd1,
        AccSub  = 2'd2
    } md_acc_t;

    localparam int unsigned DIV_CYCLES = 32;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
//   clk, rst           : clock, asynchronous active-high reset
//   start              : load dividend/divisor and begin (ignored when abort is set)
//   abort              : drop the operation in flight
//   dividend, divisor  : unsigned operands, sampled on start
//   busy               : iteration in progress
//   quotient/remainder : values after the step performed this cycle; on the
//                        final step (busy, WIDTH-th cycle) they are the result
module div_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_step;

    // quo_q doubles as the dividend shift register: its MSB is the next bit
    // brought down into the partial remainder.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_step = trial[WIDTH-1:0];
            quo_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        if (abort) begin
            busy_d = 1'b0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
        end else if (busy_q) begin
            quo_d = quo_step;
            rem_d = rem_step;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
        end
    end

    assign busy      = busy_q;
    assign quotient  = quo_step;
    assign remainder = rem_step;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO, owns HI and LO.
// Optional MADD/MADDU/MSUB/MSUBU when MULDIV_MADD_EN is defined; otherwise
// those codes behave as OpNone.
//   clk, rst           : clock, asynchronous active-high reset
//   start, op          : valid HI/LO-class instruction in EX and its md_op_t code
//   source_a, source_b : forwarded rs/rt operands
//   flush              : abort in-flight operation, suppress any HI/LO write
//   stall              : combinational pipeline freeze (IF..EX)
//   done               : registered one-cycle pulse when a mul/div completes
//   hi, lo             : architectural HI/LO registers
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] source_a,
    input  logic [DATA_W-1:0] source_b,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES);

    md_state_t           state_q, state_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic                mul_signed_q, mul_signed_d;
    md_acc_t             acc_q, acc_d;
    logic                mul_cnt_q, mul_cnt_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                stall_c;

    // Operation decode
    logic is_mul_plain, is_madd, is_div, div_signed;
    assign is_mul_plain = (op == OpMult) || (op == OpMultu);
    assign is_div       = (op == OpDiv) || (op == OpDivu);
    assign div_signed   = (op == OpDiv);
`ifdef MULDIV_MADD_EN
    assign is_madd = (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
`else
    assign is_madd = 1'b0;
`endif

    // Multiplier: 2W x 2W keeps the low 2W bits, which is the correct
    // two's-complement product when the operands are sign-extended.
    logic [2*DATA_W-1:0] a_ext, b_ext, prod_c, prod_sel, hilo, mul_result;
    always_comb begin
        a_ext = mul_signed_q ? {{DATA_W{op_a_q[DATA_W-1]}}, op_a_q} : {{DATA_W{1'b0}}, op_a_q};
        b_ext = mul_signed_q ? {{DATA_W{op_b_q[DATA_W-1]}}, op_b_q} : {{DATA_W{1'b0}}, op_b_q};
        prod_c   = a_ext * b_ext;
        prod_sel = (MUL_LAT == 2) ? prod_q : prod_c;
        hilo     = {hi_q, lo_q};
        unique case (acc_q)
            AccAdd:  mul_result = hilo + prod_sel;
            AccSub:  mul_result = hilo - prod_sel;
            default: mul_result = prod_sel;
        endcase
    end

    // Divider: core sees magnitudes; signs are restored on write-back.
    logic              div_start, div_busy;
    logic [DATA_W-1:0] div_a, div_b, div_quo, div_rem;
    always_comb begin
        div_a = (div_signed && source_a[DATA_W-1]) ? -source_a : source_a;
        div_b = (div_signed && source_b[DATA_W-1]) ? -source_b : source_b;
    end

    div_core #(
        .WIDTH (DATA_W)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .dividend  (div_a),
        .divisor   (div_b),
        .busy      (div_busy),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        mul_signed_d = mul_signed_q;
        acc_d        = acc_q;
        mul_cnt_d    = mul_cnt_q;
        prod_d       = prod_q;
        cnt_d        = cnt_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        stall_c      = 1'b0;
        div_start    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op == OpMthi) begin
                        hi_d = source_a;
                    end else if (op == OpMtlo) begin
                        lo_d = source_a;
                    end else if (is_mul_plain || is_madd) begin
                        stall_c      = 1'b1;
                        op_a_d       = source_a;
                        op_b_d       = source_b;
                        mul_signed_d = (op == OpMult) || (op == OpMadd) || (op == OpMsub);
                        acc_d        = AccNone;
                        if (is_madd) begin
                            acc_d = ((op == OpMadd) || (op == OpMaddu)) ? AccAdd : AccSub;
                        end
                        mul_cnt_d = 1'b0;
                        state_d   = StMul;
                    end else if (is_div) begin
                        stall_c = 1'b1;
                        if (source_b == '0) begin
                            // Divide by zero: complete without touching HI/LO.
                            state_d = StDone;
                        end else begin
                            div_start = 1'b1;
                            neg_quo_d = div_signed && (source_a[DATA_W-1] ^ source_b[DATA_W-1]);
                            neg_rem_d = div_signed && source_a[DATA_W-1];
                            cnt_d     = '0;
                            state_d   = StDiv;
                        end
                    end
                end
            end
            StMul: begin
                stall_c = 1'b1;
                prod_d  = prod_c;
                if (mul_cnt_q == 1'(MUL_LAT - 1)) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = StDone;
                end else begin
                    mul_cnt_d = 1'b1;
                end
            end
            StDiv: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if ((cnt_q == CntW'(DIV_CYCLES - 1)) && div_busy) begin
                    lo_d    = neg_quo_q ? -div_quo : div_quo;
                    hi_d    = neg_rem_q ? -div_rem : div_rem;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush wins over everything, including a completion on this edge.
        if (flush) begin
            state_d   = StIdle;
            hi_d      = hi_q;
            lo_d      = lo_q;
            stall_c   = 1'b0;
            div_start = 1'b0;
        end
        if (rst) begin
            stall_c = 1'b0;
        end
    end

    assign done_d = (state_d == StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hi_q         <= '0;
            lo_q         <= '0;
            done_q       <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            mul_signed_q <= 1'b0;
            acc_q        <= AccNone;
            mul_cnt_q    <= 1'b0;
            prod_q       <= '0;
            cnt_q        <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            done_q       <= done_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            mul_signed_q <= mul_signed_d;
            acc_q        <= acc_d;
            mul_cnt_q    <= mul_cnt_d;
            prod_q       <= prod_d;
            cnt_q        <= cnt_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
        end
    end

    assign stall = stall_c;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- EX-stage HI/LO unit sitting directly downstream of the operand-select stage.
- Consumes source_a/source_b and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Raises a combinational stall to freeze the pipeline while a multi-cycle operation is in flight.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- MUL_LAT, 1, multiply cycles after accept (1 or 2; 2 adds a product register stage).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  EX holds a valid HI/LO-class instruction this cycle
- op  in  4  md_op_t operation code
- source_a  in  DATA_W  first operand (rs, forwarded)
- source_b  in  DATA_W  second operand (rt, forwarded)
- flush  in  1  exception/flush; abort the in-flight operation
- stall  out  1  combinational; freeze IF..EX
- done  out  1  registered; one-cycle pulse when HI/LO update from mul/div
- hi  out  DATA_W  HI register
- lo  out  DATA_W  LO register

Behaviour:
- Reset (async): state=IDLE, hi=lo=0, done=0, internal counters/operands=0. stall=0 during reset.
- States: IDLE, MUL, DIV, DONE.
- IDLE & start & !flush:
  - op MTHI/MTLO: hi (or lo) <= source_a at the edge; no stall; stay IDLE.
  - op MULT/MULTU: latch operands; go to MUL; stall=1 this cycle.
  - op DIV/DIVU, source_b != 0: latch |a| and |b| (signed ops) or raw values; record sign flags; go to DIV, cnt=0; stall=1.
  - op DIV/DIVU, source_b == 0: go to DONE; HI/LO unchanged; stall=1 this cycle.
  - op NONE: no effect.
- MUL: stall=1.
  - After MUL_LAT cycles: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU) at the edge into DONE.
- DIV: radix-2 restoring, one quotient bit per cycle, stall=1.
  - After cnt==31 the edge into DONE writes the results.
  - Quotient goes to lo; it is negated if the operand signs differ.
  - Remainder goes to hi; it takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF signed gives lo=0x80000000, hi=0.
- DONE: stall=0, done=1; the pipeline advances this edge. start is ignored; next state IDLE.
- Latency (accept cycle to DONE): MULT = 1+MUL_LAT cycles; DIV = 33 cycles; divide-by-zero = 1 cycle.
- flush (any state):
  - stall=0 combinationally.
  - Next state IDLE; no HI/LO write, including a pending MUL/DIV completion.
  - flush with MTHI/MTLO in IDLE suppresses the write.
- Operands are latched at accept; later changes on source_a/b are ignored.
- hi/lo outputs reflect the register values only; there is no internal bypass. MFHI in the DONE cycle's successor sees the new values.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - Adds ops MADD, MADDU, MSUB and MSUBU.
  - These behave like MULT/MULTU for timing.
  - The DONE-entry edge writes {hi,lo} <= {hi,lo} ± product (64-bit, wrap on overflow).
  - Same latency.
- Undefined: those codes are decoded as NONE; no stall, no write.

Decomposition:
- Shared package muldiv_pkg holds:
  - md_op_t enum: NONE=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU.
  - md_state_t enum.
  - Constant DIV_CYCLES=32.
- Sub-module div_core: unsigned iterative divider with ports start, abort, dividend, divisor, busy, quotient, remainder.
- ex_muldiv does the sign handling and HI/LO writes.

Test Plan:
- rst pulse mid-DIV (cycle 10) -> stall=0 immediately, hi=lo=0, state IDLE; next MTLO 0x5 -> lo=0x5.
- MULT a=0xFFFFFFFF, b=0x2 -> stall high 2 cycles (MUL_LAT=1), then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse 1 cycle. MULTU same operands -> hi=0x1, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=0x2 -> stall exactly 33 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIV started, flush at cycle 10 -> stall low that cycle, hi/lo keep prior values, no done; a following DIVU 9/3 -> lo=3, hi=0.
- DIVU b=0 with hi=0x11, lo=0x22 -> 1 stall cycle, done pulse, hi/lo unchanged. MTHI 0xABCD with flush=1 -> hi unchanged.
- MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=0x1, lo=0x0. MSUB with hi=lo=0, 1*1 -> hi=lo=0xFFFFFFFF.
